// File: rtl/fm_mac_scheduler.sv
// Per-sample FM matrix sequencer: one shared MAC and one wavetable read port
// time-multiplexed across N_OSC oscillators, ending each frame with a mixed sample.
module fm_mac_scheduler #(
    parameter int unsigned N_OSC     = 4,
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned WEIGHT_W  = 8,
    parameter int unsigned PHASE_W   = 24,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MOD_SHIFT = 6
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               sample_tick,
    input  logic                               run,
    input  logic [N_OSC*N_OSC-1:0]             fm_enable,
    input  logic [N_OSC*N_OSC*WEIGHT_W-1:0]    fm_weight,
    input  logic [N_OSC*PHASE_W-1:0]           base_inc,
    output logic                               wt_req,
    output logic [$clog2(N_OSC)-1:0]           wt_osc,
    output logic [ADDR_W-1:0]                  wt_addr,
    input  logic                               wt_ack,
    input  logic [SAMPLE_W-1:0]                wt_data,
    output logic [SAMPLE_W-1:0]                mix_out,
    output logic                               mix_valid,
    output logic                               busy,
    output logic                               overrun
);

    localparam int unsigned IDX_W = $clog2(N_OSC);
    localparam int unsigned ACC_W = SAMPLE_W + WEIGHT_W + IDX_W + 1;
    localparam int unsigned SUM_W = SAMPLE_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OSC - 1);

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_PHASE, S_FETCH, S_MIX} state_e;

    state_e                      state_q;
    logic [IDX_W-1:0]            i_q, j_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic [PHASE_W-1:0]          phase_q [N_OSC];
    logic signed [SAMPLE_W-1:0]  prev_q  [N_OSC];
    logic signed [SAMPLE_W-1:0]  new_q   [N_OSC];
    logic                        wt_req_q, mix_valid_q, busy_q, overrun_q;
    logic [IDX_W-1:0]            wt_osc_q;
    logic [ADDR_W-1:0]           wt_addr_q;
    logic [SAMPLE_W-1:0]         mix_out_q;

    logic [WEIGHT_W-1:0]         weight_a [N_OSC*N_OSC];
    logic [PHASE_W-1:0]          base_a   [N_OSC];

    for (genvar k = 0; k < N_OSC*N_OSC; k++) begin : g_weight
        assign weight_a[k] = fm_weight[k*WEIGHT_W +: WEIGHT_W];
    end
    for (genvar k = 0; k < N_OSC; k++) begin : g_inc
        assign base_a[k] = base_inc[k*PHASE_W +: PHASE_W];
    end

    logic signed [SAMPLE_W-1:0]  prev_s;
    logic signed [WEIGHT_W:0]    weight_s;
    logic signed [ACC_W-1:0]     prod;
    logic signed [ACC_W-1:0]     acc_d;
    logic signed [PHASE_W-1:0]   mod_term;
    logic [PHASE_W-1:0]          phase_d;
    logic signed [SAMPLE_W-1:0]  wt_data_s;
    logic signed [SUM_W-1:0]     sum_d;
    logic [SAMPLE_W-1:0]         mix_d;

    assign wt_data_s = $signed(wt_data);

    always_comb begin
        prev_s   = prev_q[j_q];
        weight_s = {1'b0, weight_a[{i_q, j_q}]};
        prod     = '0;
        if (fm_enable[{i_q, j_q}])
            prod = ACC_W'(prev_s) * ACC_W'(weight_s);
        acc_d    = acc_q + prod;
        mod_term = PHASE_W'(acc_q >>> MOD_SHIFT);
        phase_d  = phase_q[i_q] + base_a[i_q] + mod_term;
        // The last oscillator's sample lands on the same edge the mix is taken,
        // so it is summed straight from the ROM bus.
        sum_d = '0;
        for (int unsigned k = 0; k < N_OSC; k++) begin
            if (IDX_W'(k) == i_q)
                sum_d = sum_d + SUM_W'(wt_data_s);
            else
                sum_d = sum_d + SUM_W'(new_q[k]);
        end
        mix_d = SAMPLE_W'(sum_d >>> IDX_W);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            wt_req_q    <= 1'b0;
            wt_osc_q    <= '0;
            wt_addr_q   <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned k = 0; k < N_OSC; k++) begin
                phase_q[k] <= '0;
                prev_q[k]  <= '0;
                new_q[k]   <= '0;
            end
        end else begin
            mix_valid_q <= 1'b0;
            if (sample_tick && busy_q)
                overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (sample_tick && run) begin
                        state_q <= S_MAC;
                        i_q     <= '0;
                        j_q     <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    j_q   <= j_q + 1'b1;
                    if (j_q == LAST)
                        state_q <= S_PHASE;
                end
                S_PHASE: begin
                    phase_q[i_q] <= phase_d;
                    wt_req_q     <= 1'b1;
                    wt_osc_q     <= i_q;
                    wt_addr_q    <= phase_d[PHASE_W-1 -: ADDR_W];
                    state_q      <= S_FETCH;
                end
                S_FETCH: begin
                    if (wt_ack) begin
                        new_q[i_q] <= wt_data_s;
                        wt_req_q   <= 1'b0;
                        if (i_q == LAST) begin
                            mix_out_q   <= mix_d;
                            mix_valid_q <= 1'b1;
                            state_q     <= S_MIX;
                        end else begin
                            i_q     <= i_q + 1'b1;
                            j_q     <= '0;
                            acc_q   <= '0;
                            state_q <= S_MAC;
                        end
                    end
                end
                S_MIX: begin
                    for (int unsigned k = 0; k < N_OSC; k++)
                        prev_q[k] <= new_q[k];
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wt_req    = wt_req_q;
    assign wt_osc    = wt_osc_q;
    assign wt_addr   = wt_addr_q;
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fm_mac_scheduler.sv
// Scoreboard bench for fm_mac_scheduler: a frame-level reference model queues
// expected fetches and mixes; a monitor compares them as the DUT presents them.
module tb_fm_mac_scheduler;

    localparam int N = 4;

    logic           Clk = 1'b0;
    logic           Reset, sample_tick, run;
    logic [15:0]    fm_enable;
    logic [127:0]   fm_weight;
    logic [95:0]    base_inc;
    logic           wt_req;
    logic [1:0]     wt_osc;
    logic [9:0]     wt_addr;
    logic           wt_ack;
    logic [15:0]    wt_data;
    logic [15:0]    mix_out;
    logic           mix_valid, busy, overrun;

    fm_mac_scheduler #(
        .N_OSC(4), .SAMPLE_W(16), .WEIGHT_W(8), .PHASE_W(24), .ADDR_W(10), .MOD_SHIFT(6)
    ) dut (
        .Clk(Clk), .Reset(Reset), .sample_tick(sample_tick), .run(run),
        .fm_enable(fm_enable), .fm_weight(fm_weight), .base_inc(base_inc),
        .wt_req(wt_req), .wt_osc(wt_osc), .wt_addr(wt_addr),
        .wt_ack(wt_ack), .wt_data(wt_data),
        .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    int unsigned checks = 0, errors = 0, cyc = 0;
    int unsigned rom_mode = 0;

    typedef struct { logic [1:0] osc; logic [9:0] addr; } fexp_t;
    typedef struct { logic [15:0] mix; int unsigned cyc; } mexp_t;
    fexp_t       fq[$];
    mexp_t       mq[$];
    int unsigned wq[$];

    longint            m_phase [N];
    logic signed [15:0] m_prev [N];

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] rom(input logic [1:0] o, input logic [9:0] a);
        logic [31:0] h;
        case (rom_mode)
            0: return {a, 6'b0};
            1: return 16'h0100;
            default: begin
                h = ({22'b0, a} * 32'h9E37) ^ ({30'b0, o} * 32'h3C5A1);
                return h[15:0] ^ h[31:16];
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame semantics: every modulator reads last frame's samples, so oscillator order is irrelevant.
    task automatic model_frame(input int unsigned tick_c, input int unsigned wait_sum);
        longint acc, ph, s;
        logic [9:0] addr;
        logic [15:0] samp [N];
        fexp_t f;
        mexp_t m;
        s = 0;
        for (int i = 0; i < N; i++) begin
            acc = 0;
            for (int j = 0; j < N; j++)
                if (fm_enable[i*N+j])
                    acc += longint'(m_prev[j]) * longint'(fm_weight[(i*N+j)*8 +: 8]);
            ph = (m_phase[i] + longint'(base_inc[i*24 +: 24]) + (acc >>> 6)) & 64'hFF_FFFF;
            m_phase[i] = ph;
            addr = 10'(ph >> 14);
            samp[i] = rom(2'(i), addr);
            f.osc = 2'(i);
            f.addr = addr;
            fq.push_back(f);
            s += longint'($signed(samp[i]));
        end
        for (int i = 0; i < N; i++) m_prev[i] = $signed(samp[i]);
        m.mix = 16'(s >>> 2);
        m.cyc = tick_c + 25 + wait_sum;
        mq.push_back(m);
    endtask

    // ROM: per-request wait count taken from wq; abandons the read if wt_req drops.
    initial begin
        int unsigned w;
        wt_ack = 1'b0;
        wt_data = '0;
        forever begin
            @(posedge Clk); #1;
            if (wt_req && !Reset) begin
                w = (wq.size() != 0) ? wq.pop_front() : 0;
                for (int unsigned k = 0; k < w && wt_req; k++) begin
                    @(posedge Clk); #1;
                end
                if (wt_req) begin
                    wt_data = rom(wt_osc, wt_addr);
                    wt_ack = 1'b1;
                    @(posedge Clk); #1;
                    wt_ack = 1'b0;
                end
            end
        end
    end

    // Monitor
    bit         in_fetch = 0;
    logic [1:0] cap_osc;
    logic [9:0] cap_addr;
    always @(negedge Clk) begin
        fexp_t f;
        mexp_t m;
        if (Reset) begin
            in_fetch = 0;
        end else begin
            if (wt_req) begin
                if (!in_fetch) begin
                    in_fetch = 1;
                    cap_osc = wt_osc;
                    cap_addr = wt_addr;
                end else begin
                    chk("wt_osc_stable", wt_osc, cap_osc);
                    chk("wt_addr_stable", wt_addr, cap_addr);
                end
                if (wt_ack) begin
                    in_fetch = 0;
                    if (fq.size() == 0) chk("unexpected_fetch", 1, 0);
                    else begin
                        f = fq.pop_front();
                        chk("wt_osc", wt_osc, f.osc);
                        chk("wt_addr", wt_addr, f.addr);
                    end
                end
            end else in_fetch = 0;
            if (mix_valid) begin
                chk("busy_at_mix", busy, 1);
                if (mq.size() == 0) chk("unexpected_mix", 1, 0);
                else begin
                    m = mq.pop_front();
                    chk("mix_out", mix_out, m.mix);
                    chk("mix_latency", cyc, m.cyc);
                end
            end
        end
    end

    task automatic do_frame(input int unsigned wmin, input int unsigned wmax, input bit extra_tick, input bit drop_run);
        int unsigned ws, w;
        ws = 0;
        for (int i = 0; i < N; i++) begin
            w = $urandom_range(wmax, wmin);
            wq.push_back(w);
            ws += w;
        end
        @(posedge Clk); #1;
        sample_tick = 1'b1;
        model_frame(cyc, ws);
        @(posedge Clk); #1;
        sample_tick = 1'b0;
        if (drop_run) run = 1'b0;
        if (extra_tick) begin
            repeat (9) @(posedge Clk);
            #1 sample_tick = 1'b1;
            @(posedge Clk); #1;
            sample_tick = 1'b0;
        end
        for (int t = 0; t < 400; t++) begin
            if (mq.size() == 0) break;
            @(posedge Clk);
        end
        if (mq.size() != 0) begin
            chk("frame_done", mq.size(), 0);
            fq.delete(); mq.delete(); wq.delete();
        end
        run = 1'b1;
        repeat (2) @(posedge Clk);
    endtask

    task automatic set_uniform_inc(input logic [23:0] inc);
        for (int i = 0; i < N; i++) base_inc[i*24 +: 24] = inc;
    endtask

    initial begin
        bit seen_busy, seen_req;
        Reset = 1'b1; sample_tick = 1'b0; run = 1'b0;
        fm_enable = '0; fm_weight = '0; base_inc = '0;
        for (int i = 0; i < N; i++) begin m_phase[i] = 0; m_prev[i] = '0; end
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;

        // Reset state and halted ticks
        repeat (5) @(negedge Clk);
        chk("rst_wt_req", wt_req, 0);
        chk("rst_wt_osc", wt_osc, 0);
        chk("rst_wt_addr", wt_addr, 0);
        chk("rst_mix_out", mix_out, 0);
        chk("rst_mix_valid", mix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        @(posedge Clk); #1 sample_tick = 1'b1;
        @(posedge Clk); #1 sample_tick = 1'b0;
        seen_busy = 0; seen_req = 0;
        repeat (30) begin
            @(negedge Clk);
            seen_busy |= busy;
            seen_req |= wt_req;
        end
        chk("halt_busy", seen_busy, 0);
        chk("halt_wt_req", seen_req, 0);
        chk("halt_overrun", overrun, 0);
        run = 1'b1;

        // Plain phase advance, address-shaped ROM
        rom_mode = 0;
        set_uniform_inc(24'h010000);
        do_frame(0, 0, 0, 0);
        do_frame(0, 0, 0, 0);

        // Single modulation path 1 -> 0
        rom_mode = 1;
        fm_enable = 16'h0002;
        for (int k = 0; k < 16; k++) fm_weight[k*8 +: 8] = 8'h80;
        do_frame(0, 0, 0, 0);
        do_frame(0, 0, 0, 0);

        // Slow ROM: 3 wait cycles per read
        do_frame(3, 3, 0, 0);

        // Tick during a frame
        chk("overrun_before", overrun, 0);
        do_frame(0, 0, 1, 0);
        chk("overrun_set", overrun, 1);
        do_frame(0, 1, 0, 1);
        chk("overrun_sticky", overrun, 1);

        // Reset in the middle of a fetch
        for (int i = 0; i < N; i++) wq.push_back(6);
        @(posedge Clk); #1 sample_tick = 1'b1;
        @(posedge Clk); #1 sample_tick = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (wt_req) break;
            @(posedge Clk); #1;
        end
        chk("abort_req_seen", wt_req, 1);
        @(posedge Clk); #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        @(negedge Clk);
        chk("abort_wt_req", wt_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mix_out", mix_out, 0);
        chk("abort_mix_valid", mix_valid, 0);
        chk("abort_overrun", overrun, 0);
        wq.delete();
        for (int i = 0; i < N; i++) begin m_phase[i] = 0; m_prev[i] = '0; end
        repeat (8) @(posedge Clk);
        do_frame(0, 0, 0, 0);

        // Randomized matrices, increments and ROM latency
        rom_mode = 2;
        for (int f = 0; f < 24; f++) begin
            fm_enable = 16'($urandom);
            for (int k = 0; k < 16; k++) fm_weight[k*8 +: 8] = 8'($urandom);
            for (int i = 0; i < N; i++) base_inc[i*24 +: 24] = 24'($urandom);
            do_frame(0, 3, 0, ($urandom_range(0, 3) == 0));
        end

        chk("fetch_queue_drained", fq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
